// File: rtl/mem_arbiter.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single main-memory port between the I-cache refill path and the
// D-cache refill/writeback path, and sequences fixed-length line bursts
// (BEATS words, line aligned) on that port.
//
// Arbitration happens only in IDLE. D-cache wins ties, except when the I-cache
// has already lost STARVE_LIMIT consecutive ties, in which case the I-cache wins.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   i_req / i_addr       I-cache line read request (level) and miss address
//   i_gnt / i_done       one-cycle pulses: I burst started / completed
//   i_rvalid / i_rdata   I beat strobe and data (data passes mem_rdata through)
//   d_req / d_we         D-cache request (level); 1 = writeback, 0 = refill
//   d_addr / d_wdata     D-cache address and current write beat
//   d_gnt / d_done       one-cycle pulses: D burst started / completed
//   d_rvalid / d_rdata   D read beat strobe and data
//   d_wready             D write beat accepted; requester advances d_wdata
//   mem_req / mem_we     memory beat request and write enable
//   mem_addr / mem_wdata memory word address and write data
//   mem_rdata/ mem_ready memory read data; beat completes this cycle
//   mem_stall            memory system busy (to hazard unit)
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int BEATS        = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_done,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic                  d_wready,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_done,

    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,

    output logic                  mem_stall
);

    localparam int BEAT_W   = $clog2(BEATS);
    localparam int OFFSET_W = BEAT_W + 2;
    localparam int STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    // Clears the byte-in-line offset so bursts always start on a line boundary.
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK  = ~ADDR_WIDTH'((1 << OFFSET_W) - 1);
    localparam logic [BEAT_W-1:0]     LAST_BEAT  = BEAT_W'(BEATS - 1);
    localparam logic [STARVE_W-1:0]   STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_DONE
    } state_e;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_e;

    state_e                state_q;
    owner_e                owner_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic                  we_q;
    logic [BEAT_W-1:0]     beat_q;
    logic [STARVE_W-1:0]   starve_q;
    logic                  i_gnt_q, d_gnt_q;
    logic                  i_done_q, d_done_q;

    logic                  grant_i_d;
    logic [STARVE_W-1:0]   starve_d;

    // Arbitration decision and the starvation count that goes with it; only
    // consumed when a grant is actually made in IDLE.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can
        // leave it unassigned and infer a latch.
        starve_d  = '0;
        grant_i_d = i_req && (!d_req || (starve_q == STARVE_MAX));
        if (!grant_i_d && i_req) begin
            // D beat a waiting I: count the loss, saturating at the limit.
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
        end
    end

    // Burst sequencer. gnt/done are registered one-cycle pulses: cleared by
    // default every cycle and set only on the transition that creates them.
    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q  <= S_IDLE;
            owner_q  <= OWN_D;
            base_q   <= '0;
            we_q     <= 1'b0;
            beat_q   <= '0;
            starve_q <= '0;
            i_gnt_q  <= 1'b0;
            d_gnt_q  <= 1'b0;
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
        end else begin
            i_gnt_q  <= 1'b0;
            d_gnt_q  <= 1'b0;
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (i_req || d_req) begin
                        state_q  <= S_BURST;
                        beat_q   <= '0;
                        starve_q <= starve_d;
                        if (grant_i_d) begin
                            owner_q <= OWN_I;
                            base_q  <= i_addr & LINE_MASK;
                            we_q    <= 1'b0;
                            i_gnt_q <= 1'b1;
                        end else begin
                            owner_q <= OWN_D;
                            base_q  <= d_addr & LINE_MASK;
                            we_q    <= d_we;
                            d_gnt_q <= 1'b1;
                        end
                    end
                end

                S_BURST: begin
                    if (mem_ready) begin
                        beat_q <= beat_q + 1'b1;
                        if (beat_q == LAST_BEAT) begin
                            state_q  <= S_DONE;
                            i_done_q <= (owner_q == OWN_I);
                            d_done_q <= (owner_q == OWN_D);
                        end
                    end
                end

                S_DONE: begin
                    // Requests are deliberately not sampled here; this forces
                    // at least one IDLE cycle between bursts.
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    logic burst, own_i, own_d;

    assign burst = (state_q == S_BURST);
    assign own_i = burst && (owner_q == OWN_I);
    assign own_d = burst && (owner_q == OWN_D);

    assign i_gnt  = i_gnt_q;
    assign d_gnt  = d_gnt_q;
    assign i_done = i_done_q;
    assign d_done = d_done_q;

    // base_q is line aligned, so adding the beat offset only fills the cleared
    // low bits: the address can never carry out of the line.
    assign mem_req   = burst;
    assign mem_we    = burst && we_q;
    assign mem_addr  = burst ? (base_q + ADDR_WIDTH'({beat_q, 2'b00})) : '0;
    assign mem_wdata = mem_we ? d_wdata : '0;

    // Beat strobes go only to the burst owner; the I side never writes.
    assign i_rvalid = own_i && mem_ready;
    assign d_rvalid = own_d && !we_q && mem_ready;
    assign d_wready = own_d && we_q && mem_ready;
    assign i_rdata  = own_i ? mem_rdata : '0;
    assign d_rdata  = (own_d && !we_q) ? mem_rdata : '0;

    assign mem_stall = i_req | d_req | (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter (default parameters). Fixed cycle-by-cycle
// vectors cover the single read, simultaneous request and writeback-with-wait
// cases; hand sequences cover reset, starvation and reset mid-burst; a random
// phase plays both requesters and the memory against a transaction-level model
// (who wins, which line, which beats) with random wait states.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW           = 32;
    localparam int DW           = 32;
    localparam int BEATS        = 4;
    localparam int STARVE_LIMIT = 4;

    logic          clk;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt, i_rvalid, i_done;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt, d_rvalid, d_wready, d_done;
    logic [DW-1:0] d_rdata;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          mem_stall;

    mem_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .BEATS       (BEATS),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .i_done   (i_done),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_wready (d_wready),
        .d_rdata  (d_rdata),
        .d_done   (d_done),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .mem_stall(mem_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled on the
    // falling edge of the same cycle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Plays memory for one whole burst starting at the request cycle's drive
    // point, checking every beat, then the done cycle. Ends at the negedge of
    // the done cycle.
    task automatic check_burst(input bit exp_i, input logic [31:0] base,
                               input bit we, input bit rnd);
        int k;
        int cyc;
        bit first;
        bit rdy;
        k     = 0;
        cyc   = 0;
        first = 1'b1;
        while (k < BEATS) begin
            next_cycle();
            mem_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            mem_rdata = $urandom;
            d_wdata   = $urandom;
            @(negedge clk);
            rdy = mem_ready;
            check("gnt", 32'({i_gnt, d_gnt}),
                  32'(first ? (exp_i ? 2'b10 : 2'b01) : 2'b00));
            check1("mem_req", mem_req, 1'b1);
            check("mem_addr", mem_addr, base + 32'(k * 4));
            check1("mem_we", mem_we, we);
            if (we) check("mem_wdata", mem_wdata, d_wdata);
            check1("i_rvalid", i_rvalid, exp_i && rdy);
            check1("d_rvalid", d_rvalid, !exp_i && !we && rdy);
            check1("d_wready", d_wready, !exp_i && we && rdy);
            if (rdy && !we) check("rdata", exp_i ? i_rdata : d_rdata, mem_rdata);
            check("done early", 32'({i_done, d_done}), 32'(0));
            first = 1'b0;
            if (rdy) k++;
            cyc++;
            if (cyc > 64) begin
                n_tests++;
                n_fail++;
                $display("FAIL burst timeout: %0d of %0d beats", k, BEATS);
                return;
            end
        end
        next_cycle();
        mem_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        check("done", 32'({i_done, d_done}), 32'(exp_i ? 2'b10 : 2'b01));
        check1("mem_req in done", mem_req, 1'b0);
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        return $urandom;
    endfunction

    // Vector: inputs {i_req, d_req, d_we, mem_ready}; expected flags
    // {i_gnt, i_rvalid, i_done, d_gnt, d_rvalid, d_wready, d_done,
    //  mem_req, mem_we, mem_stall}; mem_addr checked while mem_req is expected.
    typedef struct packed {
        logic [3:0]  in;
        logic [9:0]  fl;
        logic [31:0] addr;
    } vec_t;

    localparam int NV = 29;
    vec_t vec [NV];

    logic [9:0]  flags;
    bit          i_pend, d_pend, d_w, win_i, we_m;
    logic [31:0] i_a, d_a, base_m;
    int          m_starve;

    initial begin
        // Single I read at 0x1004.
        vec[0]  = '{4'b1001, 10'b0000000001, 32'h0};
        vec[1]  = '{4'b1001, 10'b1100000101, 32'h1000};
        vec[2]  = '{4'b1001, 10'b0100000101, 32'h1004};
        vec[3]  = '{4'b1001, 10'b0100000101, 32'h1008};
        vec[4]  = '{4'b1001, 10'b0100000101, 32'h100C};
        vec[5]  = '{4'b1001, 10'b0010000001, 32'h0};
        vec[6]  = '{4'b0000, 10'b0000000000, 32'h0};
        // Simultaneous reads: D first, I granted in cycle 7.
        vec[7]  = '{4'b1101, 10'b0000000001, 32'h0};
        vec[8]  = '{4'b1101, 10'b0001100101, 32'h2000};
        vec[9]  = '{4'b1101, 10'b0000100101, 32'h2004};
        vec[10] = '{4'b1101, 10'b0000100101, 32'h2008};
        vec[11] = '{4'b1101, 10'b0000100101, 32'h200C};
        vec[12] = '{4'b1101, 10'b0000001001, 32'h0};
        vec[13] = '{4'b1001, 10'b0000000001, 32'h0};
        vec[14] = '{4'b1001, 10'b1100000101, 32'h1000};
        vec[15] = '{4'b1001, 10'b0100000101, 32'h1004};
        vec[16] = '{4'b1001, 10'b0100000101, 32'h1008};
        vec[17] = '{4'b1001, 10'b0100000101, 32'h100C};
        vec[18] = '{4'b1001, 10'b0010000001, 32'h0};
        vec[19] = '{4'b0000, 10'b0000000000, 32'h0};
        // Writeback at 0x2000, mem_ready low for 2 cycles on beat 1.
        vec[20] = '{4'b0111, 10'b0000000001, 32'h0};
        vec[21] = '{4'b0111, 10'b0001010111, 32'h2000};
        vec[22] = '{4'b0110, 10'b0000000111, 32'h2004};
        vec[23] = '{4'b0110, 10'b0000000111, 32'h2004};
        vec[24] = '{4'b0111, 10'b0000010111, 32'h2004};
        vec[25] = '{4'b0111, 10'b0000010111, 32'h2008};
        vec[26] = '{4'b0111, 10'b0000010111, 32'h200C};
        vec[27] = '{4'b0111, 10'b0000001001, 32'h0};
        vec[28] = '{4'b0000, 10'b0000000000, 32'h0};

        rst       = 1'b1;
        i_req     = 1'b0;
        i_addr    = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;

        // ---- Reset state ----
        repeat (2) next_cycle();
        @(negedge clk);
        check("reset outputs", 32'({i_gnt, i_rvalid, i_done, d_gnt, d_rvalid,
                                    d_wready, d_done, mem_req, mem_we}), 32'(0));
        check("reset mem_addr", mem_addr, 32'h0);
        check1("reset mem_stall", mem_stall, 1'b0);
        next_cycle();
        i_req = 1'b1;
        @(negedge clk);
        check1("mem_stall follows req in reset", mem_stall, 1'b1);
        next_cycle();
        i_req = 1'b0;
        rst   = 1'b0;

        // ---- Fixed vectors ----
        i_addr = 32'h1004;
        d_addr = 32'h2000;
        for (int k = 0; k < NV; k++) begin
            next_cycle();
            {i_req, d_req, d_we, mem_ready} = vec[k].in;
            mem_rdata = 32'hA5A5_0000 + 32'(k);
            d_wdata   = 32'h5A5A_0000 + 32'(k);
            @(negedge clk);
            flags = {i_gnt, i_rvalid, i_done, d_gnt, d_rvalid, d_wready, d_done,
                     mem_req, mem_we, mem_stall};
            check($sformatf("vec%0d flags", k), 32'(flags), 32'(vec[k].fl));
            if (vec[k].fl[2]) check($sformatf("vec%0d mem_addr", k), mem_addr, vec[k].addr);
            if (vec[k].fl[8]) check($sformatf("vec%0d i_rdata", k), i_rdata, mem_rdata);
            if (vec[k].fl[5]) check($sformatf("vec%0d d_rdata", k), d_rdata, mem_rdata);
            if (vec[k].fl[1]) check($sformatf("vec%0d mem_wdata", k), mem_wdata, d_wdata);
        end

        // ---- Starvation: both held high, D wins 4 then I ----
        next_cycle();
        i_req  = 1'b1;
        i_addr = 32'h6000;
        d_req  = 1'b1;
        d_addr = 32'h7000;
        d_we   = 1'b0;
        for (int g = 0; g < 5; g++) begin
            check_burst(g == 4, (g == 4) ? 32'h6000 : 32'h7000, 1'b0, 1'b0);
            check($sformatf("starve after grant %0d", g), 32'(dut.starve_q),
                  (g < 4) ? 32'(g + 1) : 32'(0));
            next_cycle();
        end
        i_req = 1'b0;
        d_req = 1'b0;

        // ---- Reset during beat 2 ----
        next_cycle();
        i_req     = 1'b1;
        i_addr    = 32'h4010;
        mem_ready = 1'b1;
        repeat (3) next_cycle();
        rst   = 1'b1;
        i_req = 1'b0;
        @(negedge clk);
        check("beat 2 addr before reset", mem_addr, 32'h4018);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check1("reset abort mem_req", mem_req, 1'b0);
        check1("reset abort i_done", i_done, 1'b0);
        check1("reset abort i_rvalid", i_rvalid, 1'b0);
        check1("reset abort idle", mem_stall, 1'b0);
        check("reset abort starve", 32'(dut.starve_q), 32'(0));
        repeat (3) begin
            next_cycle();
            @(negedge clk);
            check1("no done after abort", i_done, 1'b0);
        end
        next_cycle();
        i_req  = 1'b1;
        i_addr = 32'h5008;
        check_burst(1'b1, 32'h5000, 1'b0, 1'b0);
        next_cycle();
        i_req = 1'b0;

        // ---- Random traffic against the transaction model ----
        i_pend   = 1'b0;
        d_pend   = 1'b0;
        d_w      = 1'b0;
        i_a      = '0;
        d_a      = '0;
        m_starve = 0;
        for (int r = 0; r < 80; r++) begin
            next_cycle();
            if (!i_pend && $urandom_range(0, 1) == 1) begin
                i_pend = 1'b1;
                i_a    = rand_addr();
            end
            if (!d_pend && $urandom_range(0, 3) != 0) begin
                d_pend = 1'b1;
                d_a    = rand_addr();
                d_w    = 1'($urandom_range(0, 1));
            end
            i_req  = i_pend;
            i_addr = i_a;
            d_req  = d_pend;
            d_addr = d_a;
            d_we   = d_w;
            @(negedge clk);
            check1("rand idle stall", mem_stall, i_pend || d_pend);
            check1("rand idle mem_req", mem_req, 1'b0);
            if (!(i_pend || d_pend)) continue;

            win_i = i_pend && (!d_pend || m_starve == STARVE_LIMIT);
            if (!win_i && i_pend)
                m_starve = (m_starve < STARVE_LIMIT) ? m_starve + 1 : STARVE_LIMIT;
            else
                m_starve = 0;
            base_m = (win_i ? i_a : d_a) & ~32'(BEATS * 4 - 1);
            we_m   = win_i ? 1'b0 : d_w;
            check_burst(win_i, base_m, we_m, 1'b1);
            check("rand starve", 32'(dut.starve_q), 32'(m_starve));
            if (win_i) i_pend = 1'b0;
            else       d_pend = 1'b0;
        end
        next_cycle();
        i_req = 1'b0;
        d_req = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single main-memory port between the I-cache refill path and the D-cache refill/writeback path, and sequences fixed-length line bursts on that port. It sits between the two L1 controllers and main memory. It drives `mem_stall` into the pipeline hazard unit, which holds the pipeline until both requesters are idle and no burst is in flight.

## Interface
- `ADDR_WIDTH`, 32: byte address width.
- `DATA_WIDTH`, 32: beat (word) width.
- `BEATS`, 4: words per line burst; power of two, ≥2.
- `STARVE_LIMIT`, 4: consecutive D-cache wins allowed while I-cache waits.

- `clk`  in  1: clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `i_req`  in  1: I-cache line read request; level, held until `i_done`.
- `i_addr`  in  ADDR_WIDTH: I-cache miss address.
- `i_gnt`  out  1: one-cycle pulse, I-cache burst started.
- `i_rvalid`  out  1: beat data valid for I-cache.
- `i_rdata`  out  DATA_WIDTH: beat data.
- `i_done`  out  1: one-cycle pulse, I-cache burst complete.
- `d_req`  in  1: D-cache request; level, held until `d_done`.
- `d_we`  in  1: 1 = line writeback, 0 = line refill.
- `d_addr`  in  ADDR_WIDTH: D-cache address.
- `d_wdata`  in  DATA_WIDTH: write data for the current beat.
- `d_gnt`, `d_rvalid`, `d_done`  out  1 each: same meaning as the I-side signals.
- `d_wready`  out  1: current write beat accepted; advance `d_wdata`.
- `d_rdata`  out  DATA_WIDTH: beat data.
- `mem_req`  out  1: memory beat request.
- `mem_we`  out  1: memory write.
- `mem_addr`  out  ADDR_WIDTH: word address of current beat.
- `mem_wdata`  out  DATA_WIDTH: write beat data.
- `mem_rdata`  in  DATA_WIDTH: read beat data.
- `mem_ready`  in  1: beat completes this cycle.
- `mem_stall`  out  1: to hazard unit; memory system busy.

## Operation
- States: IDLE, BURST, DONE. Registers:
  - `owner`: I or D.
  - `base`: line-aligned address.
  - `we_q`.
  - `beat`: counter, log2(BEATS) bits.
  - `starve`: counter, saturating at STARVE_LIMIT.
- IDLE:
  - If no request, stay.
  - If exactly one request, grant it.
  - If both request: grant I when `starve == STARVE_LIMIT`, otherwise grant D.
  - On a grant, latch `base = addr` with the low log2(BEATS)+2 bits cleared, latch `we_q` (D: `d_we`; I: 0), set `beat = 0`, and move to BURST.
- `starve` update at each grant:
  - D wins while `i_req` = 1: increment (saturating).
  - I wins, or `i_req` = 0: clear to 0.
- BURST:
  - Drive `mem_req` = 1, `mem_we = we_q`, `mem_addr = base + beat*4`, `mem_wdata = d_wdata`.
  - On `mem_ready`:
    - Reads: pulse the owner's `rvalid`. `i_rdata`/`d_rdata` pass `mem_rdata` through combinationally.
    - Writes: pulse `d_wready`.
    - Increment `beat`. If `beat == BEATS-1`, move to DONE.
  - Without `mem_ready`, hold all outputs stable.
- DONE: pulse the owner's `done`, `mem_req` = 0, then return to IDLE. Requests are never sampled in DONE.
- A requester must drop `req` the cycle after `done`. A `req` still high in IDLE is treated as a new request.
- `rvalid`/`wready` go only to the owner. The non-owner's outputs stay 0.
- `mem_stall = i_req | d_req | (state != IDLE)`, combinational.
- Reset values: state IDLE, `owner` D, `beat` 0, `starve` 0. Every output is 0 except `mem_stall`, which follows its inputs.
- Reset mid-burst: abort immediately. No `done` pulse; `mem_req` is 0 in the next cycle.

## Timing
- `gnt` is a registered pulse in the first BURST cycle. `mem_req` also rises in that cycle, one cycle after `req` is seen in IDLE.
- With `mem_ready` tied high: request seen in cycle 0; beats in cycles 1..BEATS; `done` in cycle BEATS+1. That is BEATS+2 cycles request-to-done.
- Each `mem_ready`-low cycle adds one cycle of latency.
- At least one IDLE cycle separates consecutive bursts.
- `mem_addr` wraps modulo 2^ADDR_WIDTH and never crosses a line boundary.

## Test plan
- **Single I read.** `i_addr`=0x1004, `mem_ready`=1, BEATS=4.
  - `mem_addr` = 0x1000, 0x1004, 0x1008, 0x100C in cycles 1-4.
  - `i_gnt` in cycle 1, four `i_rvalid` pulses, `i_done` in cycle 5.
  - `mem_stall` high from cycle 0 through cycle 5.
- **Simultaneous requests.** `i_req` and `d_req` (read) rise together.
  - D is served first; `d_done` in cycle 5.
  - I is granted at the next IDLE: `i_gnt` in cycle 7.
- **Starvation.** `d_req` re-asserted every IDLE while `i_req` is held.
  - D wins 4 consecutive bursts; the 5th grant goes to I.
  - `starve` reads 0 after the I grant.
- **Writeback with wait states.** `d_we`=1, `d_addr`=0x2000, `mem_ready` low 2 cycles on beat 1.
  - `mem_wdata` tracks `d_wdata`; exactly 4 `d_wready` pulses.
  - `d_done` in cycle 7.
- **Reset mid-burst.** `rst` asserted during beat 2.
  - Next cycle: IDLE, `mem_req`=0, no `done`, `starve`=0.
  - A new `i_req` completes normally.
